// File: rtl/mm_stage_if.sv
// mm_stage_if: Send/Ack bundle around the data-memory stage.
// slave = stage view, master = upstream/downstream environment view.
interface mm_stage_if;
   logic [39:0] PACKET_IN;
   logic [15:0] WRITE_DATA;
   logic        WRITE_EN;
   logic        LOAD_FLG;
   logic        DEL;
   logic        Send_in;
   logic        Ack_out;
   logic        Send_out;
   logic        Ack_in;
   logic [39:0] PACKET_OUT;

   modport slave (
      input  PACKET_IN, WRITE_DATA, WRITE_EN,
      input  LOAD_FLG, DEL, Send_in, Ack_in,
      output Ack_out, Send_out, PACKET_OUT
   );

   modport master (
      output PACKET_IN, WRITE_DATA, WRITE_EN,
      output LOAD_FLG, DEL, Send_in, Ack_in,
      input  Ack_out, Send_out, PACKET_OUT
   );
endinterface

// File: rtl/mm_stage.sv
// mm_stage: data-memory stage -- store, load or exchange on AUX address.
// Ports: CP clock, MR_N async active-low reset, bus = mm_stage_if.slave.
module mm_stage #(
   parameter int ADDR_W = 8
) (
   input logic       CP,
   input logic       MR_N,
   mm_stage_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_OUT  = 2'd2
   } state_t;

   state_t      state;
   logic [39:0] pkt_q;
   logic [15:0] rd_q;
   logic [15:0] mem [2**ADDR_W];

   logic              in_xfer;
   logic              out_xfer;
   logic              accept;
   logic              wr_en;
   logic              rd_en;
   logic [ADDR_W-1:0] addr;

   assign bus.Ack_out = (state == ST_IDLE) |
                        ((state == ST_OUT) & bus.Ack_in);
   assign bus.Send_out   = (state == ST_OUT);
   assign bus.PACKET_OUT = pkt_q;

   assign in_xfer  = bus.Send_in & bus.Ack_out;
   assign out_xfer = bus.Send_out & bus.Ack_in;
   // DEL swallows the packet: no memory access, no forward
   assign accept   = in_xfer & ~bus.DEL;
   assign wr_en    = accept & bus.WRITE_EN;
   assign rd_en    = accept & bus.LOAD_FLG;
   assign addr     = bus.PACKET_IN[ADDR_W-1:0];

   // read-first: rd_q sees the word before a same-edge write
   always_ff @(posedge CP) begin
      if (wr_en)
         mem[addr] <= bus.WRITE_DATA;
      if (rd_en)
         rd_q <= mem[addr];
   end

   always_ff @(posedge CP or negedge MR_N) begin
      if (!MR_N) begin
         state <= ST_IDLE;
         pkt_q <= 40'h0;
      end else begin
         unique case (state)
            ST_IDLE, ST_OUT: begin
               if (accept) begin
                  pkt_q <= bus.PACKET_IN;
                  state <= bus.LOAD_FLG ? ST_LOAD : ST_OUT;
               end else if (out_xfer) begin
                  state <= ST_IDLE;
               end
            end
            ST_LOAD: begin
               pkt_q[31:16] <= rd_q;
               state        <= ST_OUT;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mm_stage.sv
// tb_mm_stage: directed vectors for mm_stage.
// Drives on falling CP, checks on falling CP.
module tb_mm_stage;

   logic CP;
   logic MR_N;
   int   n_cmp;
   int   n_bad;

   mm_stage_if bus ();

   mm_stage #(.ADDR_W(8)) dut (
      .CP   (CP),
      .MR_N (MR_N),
      .bus  (bus.slave)
   );

   initial CP = 1'b0;
   always #5 CP = ~CP;

   task automatic chk(input string tag,
                      input logic [39:0] obs,
                      input logic [39:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [39:0] pk(input logic [5:0] opc,
                                      input logic [1:0] fl,
                                      input logic [15:0] d,
                                      input logic [15:0] a);
      return {opc, fl, d, a};
   endfunction

   task automatic drive(input logic [39:0] p,
                        input logic [15:0] wd,
                        input logic we,
                        input logic ld,
                        input logic del);
      bus.PACKET_IN  = p;
      bus.WRITE_DATA = wd;
      bus.WRITE_EN   = we;
      bus.LOAD_FLG   = ld;
      bus.DEL        = del;
      bus.Send_in    = 1'b1;
   endtask

   task automatic idle_in();
      bus.Send_in  = 1'b0;
      bus.WRITE_EN = 1'b0;
      bus.LOAD_FLG = 1'b0;
      bus.DEL      = 1'b0;
   endtask

   task automatic tick();
      @(posedge CP);
      @(negedge CP);
   endtask

   logic [39:0] pa, pb, px, pl, ps, pd, p1, p2, pq;

   initial begin
      n_cmp = 0;
      n_bad = 0;
      MR_N = 1'b0;
      bus.Ack_in = 1'b1;
      drive(pk(6'h3F, 2'b11, 16'hFFFF, 16'h0001), 16'h0, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      chk("rst_send", {39'h0, bus.Send_out}, 40'h0);
      chk("rst_ack", {39'h0, bus.Ack_out}, 40'h1);
      chk("rst_pkt", bus.PACKET_OUT, 40'h0);
      MR_N = 1'b1;

      // store A then load B from the same word
      pa = pk(6'h01, 2'b01, 16'h1234, 16'h0012);
      drive(pa, 16'hBEEF, 1'b1, 1'b0, 1'b0);
      tick();
      chk("a_send", {39'h0, bus.Send_out}, 40'h1);
      chk("a_pkt", bus.PACKET_OUT, pa);
      chk("a_ack", {39'h0, bus.Ack_out}, 40'h1);
      pb = pk(6'h02, 2'b10, 16'h0000, 16'h0012);
      drive(pb, 16'h0, 1'b0, 1'b1, 1'b0);
      tick();
      chk("b_wait_send", {39'h0, bus.Send_out}, 40'h0);
      chk("b_wait_ack", {39'h0, bus.Ack_out}, 40'h0);
      idle_in();
      tick();
      chk("b_send", {39'h0, bus.Send_out}, 40'h1);
      chk("b_pkt", bus.PACKET_OUT, pk(6'h02, 2'b10, 16'hBEEF, 16'h0012));
      tick();
      chk("b_done", {39'h0, bus.Send_out}, 40'h0);

      // exchange at address 5
      ps = pk(6'h03, 2'b00, 16'h0F0F, 16'h0005);
      drive(ps, 16'h1111, 1'b1, 1'b0, 1'b0);
      tick();
      px = pk(6'h04, 2'b01, 16'hAAAA, 16'h0005);
      drive(px, 16'h2222, 1'b1, 1'b1, 1'b0);
      tick();
      chk("x_wait_ack", {39'h0, bus.Ack_out}, 40'h0);
      idle_in();
      tick();
      chk("x_pkt", bus.PACKET_OUT, pk(6'h04, 2'b01, 16'h1111, 16'h0005));
      pl = pk(6'h05, 2'b00, 16'h0000, 16'h0005);
      drive(pl, 16'h0, 1'b0, 1'b1, 1'b0);
      tick();
      idle_in();
      tick();
      chk("x_reload", bus.PACKET_OUT, pk(6'h05, 2'b00, 16'h2222, 16'h0005));
      tick();

      // delete must not write address 7
      drive(pk(6'h06, 2'b00, 16'h0, 16'h0007), 16'h7777, 1'b1, 1'b0, 1'b0);
      tick();
      idle_in();
      tick();
      pd = pk(6'h07, 2'b11, 16'h5555, 16'h0007);
      drive(pd, 16'hDEAD, 1'b1, 1'b0, 1'b1);
      tick();
      chk("del_send", {39'h0, bus.Send_out}, 40'h0);
      chk("del_ack", {39'h0, bus.Ack_out}, 40'h1);
      drive(pk(6'h08, 2'b00, 16'h0, 16'h0007), 16'h0, 1'b0, 1'b1, 1'b0);
      tick();
      idle_in();
      tick();
      chk("del_load", bus.PACKET_OUT, pk(6'h08, 2'b00, 16'h7777, 16'h0007));
      tick();

      // back-to-back non-load packets, one per cycle
      for (int i = 0; i < 3; i++) begin
         drive(pk(6'h10 + 6'(i), 2'b01, 16'hC000 + 16'(i), 16'h0020),
               16'h0, 1'b0, 1'b0, 1'b0);
         tick();
         chk("tput_pkt", bus.PACKET_OUT,
             pk(6'h10 + 6'(i), 2'b01, 16'hC000 + 16'(i), 16'h0020));
      end
      idle_in();
      tick();

      // backpressure and address wrap
      bus.Ack_in = 1'b0;
      p1 = pk(6'h09, 2'b10, 16'h9999, 16'h0312);
      drive(p1, 16'h5A5A, 1'b1, 1'b0, 1'b0);
      tick();
      p2 = pk(6'h0A, 2'b01, 16'h0000, 16'h0412);
      drive(p2, 16'h0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         chk("bp_pkt", bus.PACKET_OUT, p1);
         chk("bp_ack", {39'h0, bus.Ack_out}, 40'h0);
         tick();
      end
      chk("bp_send", {39'h0, bus.Send_out}, 40'h1);
      bus.Ack_in = 1'b1;
      #1;
      chk("bp_ack_comb", {39'h0, bus.Ack_out}, 40'h1);
      tick();
      chk("bp_load_wait", {39'h0, bus.Send_out}, 40'h0);
      idle_in();
      tick();
      chk("wrap_pkt", bus.PACKET_OUT, pk(6'h0A, 2'b01, 16'h5A5A, 16'h0412));
      tick();

      // reset while a load is in flight
      drive(pk(6'h0B, 2'b00, 16'h0, 16'h0005), 16'h0, 1'b0, 1'b1, 1'b0);
      tick();
      idle_in();
      MR_N = 1'b0;
      #1;
      chk("mid_send", {39'h0, bus.Send_out}, 40'h0);
      chk("mid_pkt", bus.PACKET_OUT, 40'h0);
      chk("mid_ack", {39'h0, bus.Ack_out}, 40'h1);
      tick();
      chk("mid_hold", {39'h0, bus.Send_out}, 40'h0);
      MR_N = 1'b1;
      pq = pk(6'h0C, 2'b11, 16'h4321, 16'h0033);
      drive(pq, 16'h0, 1'b0, 1'b0, 1'b0);
      tick();
      chk("post_send", {39'h0, bus.Send_out}, 40'h1);
      chk("post_pkt", bus.PACKET_OUT, pq);
      idle_in();
      tick();
      chk("post_idle", {39'h0, bus.Send_out}, 40'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mm_stage.md
# mm_stage

Data-memory stage of the data-driven pipeline, placed directly downstream of the function-processing stage. It accepts the 40-bit result packet together with `WRITE_DATA`, `WRITE_EN` and `LOAD_FLG`, and performs a local data-memory write, load or exchange. It then forwards the packet, with the loaded value substituted into the data field for loads, to the next stage over the same Send/Ack handshake.

## Interface
- `ADDR_W`, default 8: data-memory address width; depth is 2^ADDR_W words of 16 bits.
- `CP`, in, 1: clock; all state updates on the rising edge.
- `MR_N`, in, 1: master reset; asynchronous, active-low.
- `PACKET_IN`, in, 40: packet from upstream. Bits [39:34] are OPC, [33:32] are flags, [31:16] are DATA, [15:0] are AUX; the memory address is AUX[ADDR_W-1:0].
- `WRITE_DATA`, in, 16: store value; qualified by `WRITE_EN`.
- `WRITE_EN`, in, 1: packet requests a memory write.
- `LOAD_FLG`, in, 1: packet requests a memory read into DATA.
- `DEL`, in, 1: packet is to be deleted (consumed, no memory op, no output).
- `Send_in`, in, 1: upstream packet valid.
- `Ack_out`, out, 1: this stage can accept a packet this cycle.
- `Send_out`, out, 1: `PACKET_OUT` valid.
- `Ack_in`, in, 1: downstream accepts this cycle.
- `PACKET_OUT`, out, 40: forwarded packet.

## Operation
- Input transfer: `Send_in & Ack_out` at a rising `CP`. Output transfer: `Send_out & Ack_in` at a rising `CP`. Inputs are sampled only on input transfer.
- Memory: 2^ADDR_W x 16. Synchronous write; synchronous read with one-cycle latency, read-first (a read and a write to the same address on the same edge return the old value). Contents are not reset.
- States:
  - IDLE: no packet held.
  - LOAD: waiting on read data.
  - OUT: packet held for downstream.
- Transitions from IDLE on input transfer:
  - `DEL=1`: packet dropped. No write, no read; stay IDLE. `DEL` overrides `WRITE_EN` and `LOAD_FLG`.
  - `LOAD_FLG=0`: if `WRITE_EN`, write `mem[addr] <= WRITE_DATA` on this edge. Register `PACKET_IN` unchanged and go to OUT.
  - `LOAD_FLG=1`: issue the read; if `WRITE_EN`, also perform the write on this edge (exchange: the packet receives the old value). Register `PACKET_IN` and go to LOAD.
- LOAD: on the next edge, replace DATA of the held packet with the read word. All other bits are unchanged. Go to OUT.
- OUT: hold the packet stable until output transfer.
  - On output transfer with no simultaneous input transfer: go to IDLE.
  - On output transfer with a simultaneous input transfer: handle the new packet exactly as from IDLE on the same edge.
- `Ack_out` per state:
  - IDLE: 1.
  - LOAD: 0.
  - OUT: equals `Ack_in`.
- Address wraps: only AUX[ADDR_W-1:0] is used; upper AUX bits pass through untouched.
- `PACKET_OUT` only changes on the edge that loads a new packet or completes a load. `Send_out` is 1 only in OUT.

## Timing
- Reset (`MR_N` low, asynchronous):
  - state goes to IDLE;
  - `Send_out=0`, `Ack_out=1`, `PACKET_OUT=40'h0`;
  - any in-flight load or held packet is discarded.
- Memory is untouched by reset, except that a write whose edge coincides with reset assertion is not guaranteed.
- After release, the first input transfer may occur on the first rising `CP` with `MR_N` high.
- Latency from input-transfer edge N:
  - non-load packet: `Send_out` high after edge N;
  - load packet: `Send_out` high after edge N+1.
- Throughput:
  - non-load packets: 1 per cycle when `Ack_in` is held high;
  - load packets: 1 per 2 cycles.
- Write-to-load ordering: a write performed at edge N is visible to any load accepted at edge N+1 or later.
- `Ack_out` in OUT is a combinational function of `Ack_in`.
- No other combinational path runs from the input port to the output port.

## Test plan
1. Reset: hold `MR_N=0` with `Send_in=1` -> `Send_out=0`, `Ack_out=1`, `PACKET_OUT=0`. Release -> first packet accepted next edge.
2. Store then load:
   - Packet A: `WRITE_EN=1`, AUX=16'h0012, `WRITE_DATA=16'hBEEF` -> A forwarded unchanged 1 cycle later.
   - Packet B: `LOAD_FLG=1`, AUX=16'h0012, DATA=16'h0000 -> B forwarded 2 cycles after acceptance with DATA=16'hBEEF.
3. Exchange: `mem[5]=16'h1111`, then a packet with `WRITE_EN=1`, `LOAD_FLG=1`, addr 5, `WRITE_DATA=16'h2222` -> output DATA=16'h1111. A following load of addr 5 returns 16'h2222.
4. Delete: `DEL=1` with `WRITE_EN=1`, addr 7, `WRITE_DATA=16'hDEAD` -> no `Send_out` and `Ack_out` stays 1. A later load of addr 7 returns the prior contents, not 16'hDEAD.
5. Backpressure:
   - `Ack_in=0` for 5 cycles while holding a packet -> `PACKET_OUT` stable, `Ack_out=0`, upstream packet not accepted.
   - Raise `Ack_in` with `Send_in=1` -> output and input transfers on the same edge; the new packet appears next cycle.
   - Address 16'h0312 with `ADDR_W=8` -> accesses word 8'h12, and AUX is forwarded as 16'h0312.
6. Reset mid-load: assert `MR_N` low in the LOAD state -> `Send_out=0` and the packet is lost. After release, a new non-load packet is forwarded normally.
